// File: rtl/fpu_esc_dispatcher.sv
// Queued ESC-opcode dispatcher: writes the FPU bridge command register, then polls status until BUSY clears.
// Optional watchdog on the polling phase is enabled by defining FPU_DISPATCH_TIMEOUT_EN.
module fpu_esc_dispatcher #(
  parameter int          QUEUE_DEPTH    = 4,
  parameter logic [19:0] BRIDGE_BASE    = 20'hFFE0,
  parameter int          POLL_INTERVAL  = 4,
  parameter int          TIMEOUT_CYCLES = 1024
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [7:0]                     instr_opcode,
  input  logic [7:0]                     instr_modrm,
  input  logic                           instr_valid,
  output logic                           instr_ready,
  input  logic                           flush,
  output logic                           done_valid,
  output logic                           done_esc,
  output logic                           done_timeout,
  output logic [15:0]                    done_status,
  output logic [19:0]                    bus_addr,
  output logic [15:0]                    bus_wdata,
  input  logic [15:0]                    bus_rdata,
  output logic                           bus_access,
  output logic                           bus_wr_en,
  input  logic                           bus_ack,
  output logic                           busy,
  output logic [$clog2(QUEUE_DEPTH):0]   queue_count
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int IVL_W = $clog2(POLL_INTERVAL + 1);

  typedef enum logic [2:0] {IDLE, POP, WRITE_CMD, POLL_WAIT, POLL_READ, COMPLETE} state_t;

  state_t             state, state_n;
  logic [15:0]        mem [QUEUE_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               full, empty, push, pop;
  logic [15:0]        head;
  logic               head_esc;
  logic [15:0]        cmd_reg;
  logic [15:0]        status_reg;
  logic [IVL_W-1:0]   ivl_cnt;
  logic               wd_hit;

  assign full     = (count == CNT_W'(QUEUE_DEPTH));
  assign empty    = (count == '0);
  assign push     = instr_valid && !full && !flush;
  assign pop      = (state == POP) && !empty && !flush;
  assign head     = mem[rd_ptr];
  assign head_esc = (head[7:3] == 5'b11011);

  // Flush wins over a simultaneous push; only not-yet-popped entries are lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {instr_modrm, instr_opcode};
    if (pop)  cmd_reg     <= head;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      status_reg <= '0;
      ivl_cnt    <= '0;
    end else begin
      if (pop)
        status_reg <= '0;
      else if (state == POLL_READ && bus_ack)
        status_reg <= bus_rdata;
      if ((state == WRITE_CMD || state == POLL_READ) && bus_ack)
        ivl_cnt <= IVL_W'(POLL_INTERVAL);
      else if (state == POLL_WAIT && ivl_cnt != '0)
        ivl_cnt <= ivl_cnt - IVL_W'(1);
    end
  end

`ifdef FPU_DISPATCH_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt;
  logic            timeout_reg;

  assign wd_hit = (wd_cnt >= WD_W'(TIMEOUT_CYCLES));

  // Watchdog saturates at the limit so a long outstanding read cannot wrap it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wd_cnt      <= '0;
      timeout_reg <= 1'b0;
    end else begin
      if (state == WRITE_CMD && bus_ack)
        wd_cnt <= '0;
      else if ((state == POLL_WAIT || state == POLL_READ) && !wd_hit)
        wd_cnt <= wd_cnt + WD_W'(1);
      if (pop)
        timeout_reg <= 1'b0;
      else if (wd_hit && (state == POLL_WAIT || (state == POLL_READ && bus_ack)))
        timeout_reg <= 1'b1;
    end
  end

  assign done_timeout = (state == COMPLETE) && timeout_reg;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign wd_hit       = 1'b0;
  assign done_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:      if (!empty) state_n = POP;
      POP: begin
        if (flush || empty) state_n = IDLE;
        else if (head_esc)  state_n = WRITE_CMD;
        else                state_n = COMPLETE;
      end
      WRITE_CMD: if (bus_ack) state_n = POLL_WAIT;
      POLL_WAIT: begin
        if (wd_hit)                    state_n = COMPLETE;
        else if (ivl_cnt <= IVL_W'(1)) state_n = POLL_READ;
      end
      POLL_READ: begin
        if (bus_ack) begin
          if (!bus_rdata[15] || wd_hit) state_n = COMPLETE;
          else                          state_n = POLL_WAIT;
        end
      end
      COMPLETE:  state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end

  // Bus strobes are pure decodes of the state, so an async reset drops them at once.
  always_comb begin
    bus_access = 1'b0;
    bus_wr_en  = 1'b0;
    bus_addr   = '0;
    bus_wdata  = '0;
    if (state == WRITE_CMD) begin
      bus_access = 1'b1;
      bus_wr_en  = 1'b1;
      bus_addr   = BRIDGE_BASE;
      bus_wdata  = cmd_reg;
    end else if (state == POLL_READ) begin
      bus_access = 1'b1;
      bus_addr   = BRIDGE_BASE + 20'd2;
    end
  end

  assign done_valid  = (state == COMPLETE);
  assign done_esc    = (state == COMPLETE) && (cmd_reg[7:3] == 5'b11011);
  assign done_status = (state == COMPLETE) ? status_reg : 16'h0000;
  assign instr_ready = !full;
  assign queue_count = count;
  assign busy        = (state != IDLE) || !empty;

endmodule

// File: tb/tb_fpu_esc_dispatcher.sv
// Directed bench for fpu_esc_dispatcher with a bridge responder model and done/bus logging.
module tb_fpu_esc_dispatcher;
  localparam int QD = 4;
  localparam int PI = 4;
  localparam int TO = 64;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  instr_opcode = '0, instr_modrm = '0;
  logic        instr_valid = 1'b0, flush = 1'b0;
  logic        instr_ready, done_valid, done_esc, done_timeout;
  logic [15:0] done_status, bus_wdata;
  logic [15:0] bus_rdata = '0;
  logic [19:0] bus_addr;
  logic        bus_access, bus_wr_en;
  logic        bus_ack = 1'b0;
  logic        busy;
  logic [2:0]  queue_count;

  fpu_esc_dispatcher #(.QUEUE_DEPTH(QD), .BRIDGE_BASE(20'hFFE0), .POLL_INTERVAL(PI),
                       .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n), .instr_opcode(instr_opcode), .instr_modrm(instr_modrm),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .flush(flush),
    .done_valid(done_valid), .done_esc(done_esc), .done_timeout(done_timeout),
    .done_status(done_status), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_access(bus_access), .bus_wr_en(bus_wr_en),
    .bus_ack(bus_ack), .busy(busy), .queue_count(queue_count));

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int          cyc = 0;
  int          wr_delay = 0, rd_delay = 0, wait_cnt = 0;
  logic [15:0] rd_q[$];
  logic [15:0] rd_default = 16'h0000;
  bit          in_req = 0;
  logic [19:0] req_addr;
  logic [15:0] req_wdata;
  logic        req_wr;
  int          stab_err = 0, n_wr = 0, n_rd = 0, bad_rd_addr = 0, last_wait = 0, wack_cyc = 0;
  logic [15:0] wr_log[$];
  logic [19:0] wr_addr_log[$];
  int          rd_cyc[$];
  logic [17:0] dq[$];
  int          dcyc[$];
  int          max_cnt = 0;
  int          push_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Bridge responder and monitor, evaluated mid-cycle.
  always @(negedge clk) begin
    if (int'(queue_count) > max_cnt) max_cnt = int'(queue_count);
    if (done_valid) begin
      dq.push_back({done_timeout, done_esc, done_status});
      dcyc.push_back(cyc);
    end
    if (bus_access) begin
      if (!in_req) begin
        in_req = 1; req_addr = bus_addr; req_wdata = bus_wdata; req_wr = bus_wr_en; wait_cnt = 0;
      end else if (bus_addr !== req_addr || bus_wdata !== req_wdata || bus_wr_en !== req_wr) begin
        stab_err++;
      end
      if (wait_cnt == (bus_wr_en ? wr_delay : rd_delay)) begin
        bus_ack = 1'b1; in_req = 0; last_wait = wait_cnt;
        if (bus_wr_en) begin
          n_wr++; wr_log.push_back(bus_wdata); wr_addr_log.push_back(bus_addr); wack_cyc = cyc;
        end else begin
          n_rd++;
          if (bus_addr !== 20'hFFE2) bad_rd_addr++;
          rd_cyc.push_back(cyc);
          if (rd_q.size() > 0) bus_rdata = rd_q.pop_front();
          else                 bus_rdata = rd_default;
        end
      end else begin
        bus_ack = 1'b0; wait_cnt++;
      end
    end else begin
      if (in_req) begin stab_err++; in_req = 0; end
      bus_ack = 1'b0;
    end
  end

  task automatic clear_logs();
    dq.delete(); dcyc.delete(); wr_log.delete(); wr_addr_log.delete(); rd_cyc.delete();
    n_wr = 0; n_rd = 0; bad_rd_addr = 0; max_cnt = 0;
  endtask

  task automatic push(input logic [7:0] op, input logic [7:0] md);
    @(negedge clk);
    instr_opcode = op; instr_modrm = md; instr_valid = 1'b1;
    @(posedge clk);
    push_cyc = cyc;
  endtask

  task automatic idle_in();
    @(negedge clk);
    instr_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int n, input int limit);
    for (int k = 0; k < limit && dq.size() < n; k++) @(negedge clk);
    chk(tag, dq.size(), n);
  endtask

  task automatic wait_writes(input string tag, input int n, input int limit);
    for (int k = 0; k < limit && n_wr < n; k++) @(negedge clk);
    chk(tag, n_wr, n);
  endtask

  initial begin
    #20000000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int gap_min, n_before;
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ready", instr_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_count", queue_count, 0);
    chk("rst_done", {done_valid, done_esc, done_timeout, done_status}, 0);
    chk("rst_bus", {bus_access, bus_wr_en, bus_addr, bus_wdata}, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Non-ESC: done in the 4th cycle counting the push cycle, no bus traffic
    clear_logs();
    push(8'h90, 8'h00);
    idle_in();
    wait_done("t1_done", 1, 20);
    chk("t1_latency", dcyc[0] - push_cyc, 3);
    chk("t1_esc", dq[0][16], 0);
    chk("t1_status", dq[0][15:0], 16'h0000);
    chk("t1_bus", n_wr + n_rd, 0);

    // ESC D9/C0, two busy reads then ready
    repeat (3) @(negedge clk);
    clear_logs();
    rd_q = '{16'h8000, 16'h8000, 16'h0000};
    push(8'hD9, 8'hC0);
    idle_in();
    wait_done("t2_done", 1, 100);
    chk("t2_nwr", n_wr, 1);
    chk("t2_wdata", wr_log[0], 16'hC0D9);
    chk("t2_waddr", wr_addr_log[0], 20'hFFE0);
    chk("t2_nrd", n_rd, 3);
    chk("t2_raddr", bad_rd_addr, 0);
    gap_min = 1000;
    for (int i = 1; i < rd_cyc.size(); i++)
      if (rd_cyc[i] - rd_cyc[i-1] < gap_min) gap_min = rd_cyc[i] - rd_cyc[i-1];
    chk("t2_gap_ge", gap_min >= PI + 1, 1);
    chk("t2_esc", dq[0][16], 1);
    chk("t2_status", dq[0][15:0], 16'h0000);
    chk("t2_tmo", dq[0][17], 0);

    // Write ack delayed by 3 cycles
    repeat (3) @(negedge clk);
    clear_logs();
    stab_err = 0;
    wr_delay = 3;
    rd_q = '{16'h0000};
    push(8'hDD, 8'h05);
    idle_in();
    wait_done("t3_done", 1, 100);
    chk("t3_wait", last_wait, 0);
    chk("t3_stable", stab_err, 0);
    chk("t3_nwr", n_wr, 1);
    chk("t3_wdata", wr_log[0], 16'h05DD);
    wr_delay = 0;

    // FIFO fill while first ESC stalls busy
    repeat (3) @(negedge clk);
    clear_logs();
    rd_default = 16'h8000;
    push(8'hD8, 8'h01);
    idle_in();
    wait_writes("t4_first_wr", 1, 20);
    push(8'h90, 8'h02);
    push(8'hD9, 8'h03);
    push(8'h91, 8'h04);
    push(8'hDA, 8'h05);
    @(negedge clk);
    instr_opcode = 8'hDB; instr_modrm = 8'h06;
    chk("t4_ready_low", instr_ready, 0);
    chk("t4_count4", queue_count, 4);
    repeat (2) @(posedge clk);
    idle_in();
    chk("t4_count_hold", queue_count, 4);
    rd_default = 16'h0000;
    wait_done("t4_done", 5, 300);
    chk("t4_order_esc", {dq[0][16], dq[1][16], dq[2][16], dq[3][16], dq[4][16]}, 5'b10101);
    chk("t4_tmo", {dq[0][17], dq[1][17], dq[2][17], dq[3][17], dq[4][17]}, 0);
    chk("t4_nwr", n_wr, 3);
    chk("t4_wr0", wr_log[0], 16'h01D8);
    chk("t4_wr1", wr_log[1], 16'h03D9);
    chk("t4_wr2", wr_log[2], 16'h05DA);
    chk("t4_peak", max_cnt, 4);

`ifdef FPU_DISPATCH_TIMEOUT_EN
    // Watchdog: status stuck busy
    repeat (3) @(negedge clk);
    clear_logs();
    rd_default = 16'h8000;
    push(8'hDB, 8'h07);
    idle_in();
    wait_done("t5_done", 1, 200);
    chk("t5_tmo", dq[0][17], 1);
    chk("t5_status", dq[0][15:0], 16'h8000);
    chk("t5_bound", (dcyc[0] - wack_cyc >= TO) && (dcyc[0] - wack_cyc <= TO + PI + 2), 1);
    rd_default = 16'h0000;
`endif

    // Flush with 3 queued entries while one entry is polling
    repeat (3) @(negedge clk);
    clear_logs();
    rd_default = 16'h8000;
    push(8'hDC, 8'h08);
    idle_in();
    wait_writes("t6_first_wr", 1, 20);
    push(8'h90, 8'h09);
    push(8'hDD, 8'h0A);
    push(8'hDE, 8'h0B);
    idle_in();
    chk("t6_count3", queue_count, 3);
    for (int k = 0; k < 20 && !(bus_access && !bus_wr_en); k++) @(negedge clk);
    chk("t6_in_read", bus_access && !bus_wr_en, 1);
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    chk("t6_count0", queue_count, 0);
    n_before = n_wr;
    rd_default = 16'h0000;
    wait_done("t6_done", 1, 100);
    repeat (20) @(negedge clk);
    chk("t6_only_one", dq.size(), 1);
    chk("t6_esc", dq[0][16], 1);
    chk("t6_no_cmd", n_wr, n_before);
    chk("t6_idle", busy, 0);

    // Async reset mid-transaction drops the bus request immediately
    clear_logs();
    wr_delay = 3;
    push(8'hDE, 8'h0C);
    push(8'h90, 8'h0D);
    idle_in();
    for (int k = 0; k < 20 && !bus_access; k++) @(negedge clk);
    chk("t7_access", bus_access, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("t7_drop", bus_access, 0);
    chk("t7_count", queue_count, 0);
    chk("t7_busy", busy, 0);
    @(negedge clk);
    reset_n = 1'b1;
    wr_delay = 0;
    repeat (5) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
